mold_msg_framer: RTL and testbench



---
 rtl/mold_msg_framer.sv | 168 ++++++++++++++++
 tb/tb_mold_msg_framer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mold_msg_framer.sv
// Reassembles MoldUDP64 message beats into one wide byte-aligned record per message
// and hands completed records to the ITCH parser through a 2-entry queue.
module mold_msg_framer #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W/8,
  parameter int MAX_BYTES  = 64,
  parameter int LEN_W      = 16,
  parameter int FLUSH_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    mold_msg_v_i,
  input  logic                    mold_msg_start_i,
  input  logic [AXI_KEEP_W-1:0]   mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0]   mold_msg_data_i,
  output logic                    msg_v_o,
  output logic [LEN_W-1:0]        msg_len_o,
  output logic [7:0]              msg_type_o,
  output logic [8*MAX_BYTES-1:0]  msg_data_o,
  output logic                    msg_trunc_o,
  output logic                    ovf_err_o
);
  localparam int BUF_W  = 8*MAX_BYTES;
  localparam int CW     = LEN_W + 1;
  localparam int IDLE_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CW-1:0]     MAX_B     = CW'(MAX_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYC - 1);

  typedef struct packed {
    logic             trunc;
    logic [LEN_W-1:0] len;
    logic [BUF_W-1:0] data;
  } rec_t;

  function automatic logic [CW-1:0] popcnt(input logic [AXI_KEEP_W-1:0] m);
    logic [CW-1:0] n;
    n = '0;
    for (int j = 0; j < AXI_KEEP_W; j++) n = n + CW'(m[j]);
    return n;
  endfunction

  function automatic logic [LEN_W-1:0] sat_len(input logic [CW-1:0] s);
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  logic              r_open, r_trunc, r_ovf;
  logic [LEN_W-1:0]  r_cnt;
  logic [BUF_W-1:0]  r_buf;
  logic [IDLE_W-1:0] r_idle;
  rec_t              r_q [2];
  logic [1:0]        r_q_cnt;
  logic              r_msg_v, r_msg_trunc;
  logic [LEN_W-1:0]  r_msg_len;
  logic [7:0]        r_msg_type;
  logic [BUF_W-1:0]  r_msg_data;

  logic              w_beat, w_full, w_write, w_comp_a, w_comp_b, w_flush, w_deq, w_ovf;
  logic [CW-1:0]     w_k, w_sum;
  logic [LEN_W-1:0]  w_base_cnt, w_new_cnt;
  logic [BUF_W-1:0]  w_base_buf, w_new_buf;
  logic [AXI_DATA_W-1:0] w_masked;
  logic              w_new_trunc;
  rec_t              w_rec_cur, w_rec_b;
  rec_t              w_nq [2];
  logic [1:0]        w_nc;

  always_comb begin
    w_masked = '0;
    for (int j = 0; j < AXI_KEEP_W; j++)
      w_masked[8*j +: 8] = mold_msg_data_i[8*j +: 8] & {8{mold_msg_mask_i[j]}};
  end

  assign w_beat      = mold_msg_v_i && (|mold_msg_mask_i);
  assign w_full      = &mold_msg_mask_i;
  assign w_write     = w_beat && (mold_msg_start_i || r_open);
  assign w_k         = popcnt(mold_msg_mask_i);
  // A start beat assembles on top of an empty buffer; the old one is still visible for completion A.
  assign w_base_cnt  = mold_msg_start_i ? '0 : r_cnt;
  assign w_base_buf  = mold_msg_start_i ? '0 : r_buf;
  assign w_sum       = {1'b0, w_base_cnt} + w_k;
  assign w_new_cnt   = sat_len(w_sum);
  assign w_new_trunc = (!mold_msg_start_i && r_trunc) || (w_sum > MAX_B);
  assign w_new_buf   = w_base_buf | (BUF_W'(w_masked) << {w_base_cnt, 3'b000});

  assign w_comp_a  = w_beat && mold_msg_start_i && r_open;
  assign w_flush   = r_open && !mold_msg_v_i && (r_idle == IDLE_LAST);
  assign w_comp_b  = (w_write && !w_full) || w_flush;
  assign w_rec_cur = {r_trunc, r_cnt, r_buf};
  assign w_rec_b   = w_flush ? w_rec_cur : {w_new_trunc, w_new_cnt, w_new_buf};
  assign w_deq     = (r_q_cnt != 2'd0);

  // Queue update: pop the head into the output stage, then push A before B.
  always_comb begin
    w_nq  = r_q;
    w_nc  = r_q_cnt;
    w_ovf = 1'b0;
    if (w_deq) begin
      w_nq[0] = r_q[1];
      w_nc    = r_q_cnt - 2'd1;
    end
    if (w_comp_a) begin
      if (w_nc < 2'd2) begin
        w_nq[w_nc[0]] = w_rec_cur;
        w_nc          = w_nc + 2'd1;
      end else begin
        w_ovf = 1'b1;
      end
    end
    if (w_comp_b) begin
      if (w_nc < 2'd2) begin
        w_nq[w_nc[0]] = w_rec_b;
        w_nc          = w_nc + 2'd1;
      end else begin
        w_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      r_open      <= 1'b0;
      r_trunc     <= 1'b0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_idle      <= '0;
      r_q[0]      <= '0;
      r_q[1]      <= '0;
      r_q_cnt     <= 2'd0;
      r_ovf       <= 1'b0;
      r_msg_v     <= 1'b0;
      r_msg_len   <= '0;
      r_msg_type  <= 8'h00;
      r_msg_data  <= '0;
      r_msg_trunc <= 1'b0;
    end else begin
      r_q     <= w_nq;
      r_q_cnt <= w_nc;
      r_ovf   <= r_ovf | w_ovf;
      r_msg_v <= w_deq;
      if (w_deq) begin
        r_msg_len   <= r_q[0].len;
        r_msg_type  <= r_q[0].data[7:0];
        r_msg_data  <= r_q[0].data;
        r_msg_trunc <= r_q[0].trunc;
      end
      if (w_write) begin
        r_open  <= w_full;
        r_cnt   <= w_new_cnt;
        r_buf   <= w_new_buf;
        r_trunc <= w_new_trunc;
      end else if (w_flush) begin
        r_open <= 1'b0;
      end
      // Valid beats with an empty mask leave the idle count untouched.
      if (w_beat)
        r_idle <= '0;
      else if (!mold_msg_v_i)
        r_idle <= (r_open && !w_flush) ? r_idle + IDLE_W'(1) : '0;
    end
  end

  assign msg_v_o     = r_msg_v;
  assign msg_len_o   = r_msg_len;
  assign msg_type_o  = r_msg_type;
  assign msg_data_o  = r_msg_data;
  assign msg_trunc_o = r_msg_trunc;
  assign ovf_err_o   = r_ovf;
endmodule

// File: tb/tb_mold_msg_framer.sv
// Bench for mold_msg_framer: directed vector table, hand sequences, and random
// beats checked against a byte-queue reference model (two MAX_BYTES settings).
module tb_mold_msg_framer;
  localparam int FLUSH = 4;

  logic clk = 1'b0;
  logic nreset, v, st;
  logic [7:0]  mask;
  logic [63:0] data;
  logic        o64_v, o64_tr, o64_ovf, o16_v, o16_tr, o16_ovf;
  logic [15:0] o64_len, o16_len;
  logic [7:0]  o64_ty, o16_ty;
  logic [511:0] o64_d;
  logic [127:0] o16_d;

  always #5 clk = ~clk;

  mold_msg_framer #(.MAX_BYTES(64), .FLUSH_CYC(FLUSH)) dut (
    .clk(clk), .nreset(nreset), .mold_msg_v_i(v), .mold_msg_start_i(st),
    .mold_msg_mask_i(mask), .mold_msg_data_i(data), .msg_v_o(o64_v),
    .msg_len_o(o64_len), .msg_type_o(o64_ty), .msg_data_o(o64_d),
    .msg_trunc_o(o64_tr), .ovf_err_o(o64_ovf));

  mold_msg_framer #(.MAX_BYTES(16), .FLUSH_CYC(FLUSH)) dut16 (
    .clk(clk), .nreset(nreset), .mold_msg_v_i(v), .mold_msg_start_i(st),
    .mold_msg_mask_i(mask), .mold_msg_data_i(data), .msg_v_o(o16_v),
    .msg_len_o(o16_len), .msg_type_o(o16_ty), .msg_data_o(o16_d),
    .msg_trunc_o(o16_tr), .ovf_err_o(o16_ovf));

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Reference model: whole messages kept as byte queues, records scheduled on a FIFO timeline.
  typedef struct {
    int           due;
    int           len;
    logic [7:0]   typ;
    logic         tr64;
    logic         tr16;
    logic [511:0] d64;
    logic [127:0] d16;
  } exp_t;
  exp_t       expq[$];
  logic [7:0] m_bytes[$];
  bit         m_open = 0;
  int         m_idle = 0;
  int         last_due = 0;

  function automatic void emit(input int edge_no);
    exp_t e;
    int n;
    n = m_bytes.size();
    e.due = (edge_no + 1 > last_due + 1) ? edge_no + 1 : last_due + 1;
    last_due = e.due;
    e.len  = (n > 65535) ? 65535 : n;
    e.typ  = (n > 0) ? m_bytes[0] : 8'h00;
    e.tr64 = (n > 64);
    e.tr16 = (n > 16);
    e.d64  = '0;
    e.d16  = '0;
    for (int i = 0; i < n && i < 64; i++) e.d64[8*i +: 8] = m_bytes[i];
    for (int i = 0; i < n && i < 16; i++) e.d16[8*i +: 8] = m_bytes[i];
    expq.push_back(e);
  endfunction

  function automatic void model_edge(input int edge_no);
    int k;
    if (nreset) begin
      m_open = 0; m_bytes.delete(); m_idle = 0; expq.delete(); last_due = 0;
      return;
    end
    k = $countones(mask);
    if (v && k != 0) begin
      m_idle = 0;
      if (st) begin
        if (m_open) emit(edge_no);
        m_bytes.delete();
        m_open = 1;
      end
      if (m_open) begin
        for (int j = 0; j < k; j++) m_bytes.push_back(data[8*j +: 8]);
        if (k != 8) begin emit(edge_no); m_open = 0; end
      end
    end else if (!v && m_open) begin
      m_idle++;
      if (m_idle == FLUSH) begin emit(edge_no); m_open = 0; end
    end
  endfunction

  task automatic monitor();
    logic want;
    exp_t e;
    want = (expq.size() != 0) && (expq[0].due == cyc);
    chk("model_v64", 512'(o64_v), 512'(want));
    chk("model_v16", 512'(o16_v), 512'(want));
    if (want) begin
      e = expq.pop_front();
      if (o64_v && o16_v) begin
        chk("model_len64", 512'(o64_len), 512'(e.len));
        chk("model_type64", 512'(o64_ty), 512'(e.typ));
        chk("model_trunc64", 512'(o64_tr), 512'(e.tr64));
        chk("model_data64", o64_d, e.d64);
        chk("model_len16", 512'(o16_len), 512'(e.len));
        chk("model_trunc16", 512'(o16_tr), 512'(e.tr16));
        chk("model_data16", 512'(o16_d), 512'(e.d16));
      end
    end
  endtask

  task automatic step();
    model_edge(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic drive(input logic vv, input logic ss, input logic [7:0] mm, input logic [63:0] dd);
    v = vv; st = ss; mask = mm; data = dd;
  endtask

  typedef struct {
    logic v, st;
    logic [7:0] mask;
    logic [63:0] data;
    logic ev;
    logic [15:0] elen;
    logic [7:0] etype;
    logic [127:0] edata;
  } vec_t;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 64'h0706050403020100, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h0F, 64'hEEEEEEEE0B0A0908, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 16'd12, 8'h00, 128'h0B0A09080706050403020100};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[4]  = '{1'b1, 1'b1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[5]  = '{1'b1, 1'b1, 8'hFF, 64'hBBBBBBBBBBBBBBBB, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[6]  = '{1'b1, 1'b1, 8'h07, 64'hFFFFFFFFFF332211, 1'b1, 16'd8, 8'hAA, 128'hAAAAAAAAAAAAAAAA};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 16'd8, 8'hBB, 128'hBBBBBBBBBBBBBBBB};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 16'd3, 8'h11, 128'h332211};
    vecs[9]  = '{1'b1, 1'b1, 8'hFF, 64'h1111111111111111, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[10] = '{1'b1, 1'b1, 8'h01, 64'hDEADBEEFCAFE0046, 1'b0, 16'd0, 8'h00, 128'h0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 16'd8, 8'h11, 128'h1111111111111111};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 16'd1, 8'h46, 128'h46};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 16'd0, 8'h00, 128'h0};

    nreset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    step();
    chk("rst_v", 512'(o64_v), 512'(0));
    chk("rst_len", 512'(o64_len), 512'(0));
    chk("rst_type", 512'(o64_ty), 512'(0));
    chk("rst_data", o64_d, 512'(0));
    chk("rst_trunc", 512'(o64_tr), 512'(0));
    chk("rst_ovf", 512'(o64_ovf), 512'(0));
    chk("rst_v16", 512'(o16_v), 512'(0));
    nreset = 1'b0;

    for (int r = 0; r < 14; r++) begin
      drive(vecs[r].v, vecs[r].st, vecs[r].mask, vecs[r].data);
      step();
      chk($sformatf("tbl%0d_v", r), 512'(o64_v), 512'(vecs[r].ev));
      if (vecs[r].ev) begin
        chk($sformatf("tbl%0d_len", r), 512'(o64_len), 512'(vecs[r].elen));
        chk($sformatf("tbl%0d_type", r), 512'(o64_ty), 512'(vecs[r].etype));
        chk($sformatf("tbl%0d_data", r), 512'(o64_d[127:0]), 512'(vecs[r].edata));
        chk($sformatf("tbl%0d_hi", r), o64_d >> 128, 512'(0));
        chk($sformatf("tbl%0d_trunc", r), 512'(o64_tr), 512'(0));
        chk($sformatf("tbl%0d_ovf", r), 512'(o64_ovf), 512'(0));
      end
    end

    drive(1'b1, 1'b1, 8'hFF, 64'h8877665544332211);
    step();
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    for (int i = 1; i <= FLUSH + 3; i++) begin
      step();
      chk($sformatf("flush_v%0d", i), 512'(o64_v), 512'(i == FLUSH + 1));
      if (i == FLUSH + 1) chk("flush_len", 512'(o64_len), 512'(8));
    end

    drive(1'b1, 1'b1, 8'hFF, 64'h0706050403020100); step();
    drive(1'b1, 1'b0, 8'hFF, 64'h0F0E0D0C0B0A0908); step();
    drive(1'b1, 1'b0, 8'hFF, 64'h1716151413121110); step();
    drive(1'b1, 1'b0, 8'h03, 64'hCCCCCCCCCCCC1918); step();
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("trunc_v16", 512'(o16_v), 512'(1));
    chk("trunc_len16", 512'(o16_len), 512'(26));
    chk("trunc_flag16", 512'(o16_tr), 512'(1));
    chk("trunc_data16", 512'(o16_d), 512'(128'h0F0E0D0C0B0A09080706050403020100));
    chk("trunc_len64", 512'(o64_len), 512'(26));
    chk("trunc_flag64", 512'(o64_tr), 512'(0));
    step();
    step();

    drive(1'b1, 1'b1, 8'hFF, 64'h2222222222222222); step();
    drive(1'b1, 1'b1, 8'hFF, 64'h3333333333333333); step();
    nreset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("midrst_v", 512'(o64_v), 512'(0));
    chk("midrst_len", 512'(o64_len), 512'(0));
    chk("midrst_data", o64_d, 512'(0));
    nreset = 1'b0;
    drive(1'b1, 1'b0, 8'hFF, 64'h4444444444444444); step();
    drive(1'b1, 1'b0, 8'h0F, 64'h5555555555555555); step();
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    for (int i = 0; i < FLUSH + 2; i++) begin
      step();
      chk("postrst_quiet", 512'(o64_v), 512'(0));
    end
    drive(1'b1, 1'b1, 8'h1F, 64'hEEEEEE0504030201); step();
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("postrst_v", 512'(o64_v), 512'(1));
    chk("postrst_len", 512'(o64_len), 512'(5));
    chk("postrst_type", 512'(o64_ty), 512'(8'h01));
    chk("postrst_data", o64_d, 512'(40'h0504030201));
    step();

    for (int n = 0; n < 1500; n++) begin
      int kk;
      nreset = ($urandom_range(0, 399) == 0);
      kk = $urandom_range(0, 11);
      if (kk > 8) kk = 8;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            8'((9'h1 << kk) - 9'h1), {$urandom, $urandom});
      step();
    end
    nreset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 64'h0);
    for (int i = 0; i < 12; i++) step();
    chk("drain_empty", 512'(expq.size()), 512'(0));
    chk("ovf64", 512'(o64_ovf), 512'(0));
    chk("ovf16", 512'(o16_ovf), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
